// File: rtl/ntt_ctrl.sv
`timescale 1ns/1ps
// ntt_ctrl -- address and sequence controller for one forward NTT
// (Cooley-Tukey, N = 2^LOG_N points) on a single registered butterfly.
//
// Issues one butterfly per cycle: a read of a[j] / a[j+len] from the
// dual-port coefficient RAM and of zeta[k] from the twiddle ROM. The same
// addresses come back PIPE = RD_LAT + BT_LAT cycles later as the in-place
// write-back. Each layer is N/2 issue cycles followed by PIPE drain cycles,
// so the last write of a layer lands before the first read of the next.
//
// Ports:
//   clk                 clock, everything on the rising edge
//   reset               synchronous reset, active-high
//   start               transform request, sampled only while idle
//   busy                high for the whole transform
//   done                one-cycle pulse after the final write-back is issued
//   rd_en               RAM / ROM read strobe
//   rd_addr0, rd_addr1  addresses of a[j] and a[j+len]
//   tw_addr             zeta ROM index k (1..N-1)
//   wr_en               write-back strobe for both RAM ports
//   wr_addr0, wr_addr1  write-back destinations (read addresses delayed)
//   cycle_cnt           busy-cycle counter, present only when the macro
//                       NTT_CTRL_PERF_EN is defined
module ntt_ctrl #(
  parameter int LOG_N  = 8,
  parameter int RD_LAT = 1,
  parameter int BT_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr0,
  output logic [LOG_N-1:0] rd_addr1,
  output logic [LOG_N-1:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr0,
`ifdef NTT_CTRL_PERF_EN
  output logic [LOG_N-1:0] wr_addr1,
  output logic [15:0]      cycle_cnt
`else
  output logic [LOG_N-1:0] wr_addr1
`endif
);

  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int PIPE = RD_LAT + BT_LAT;
  localparam int BW   = LOG_N - 1;                 // butterfly counter width
  localparam int LW   = (LOG_N > 1) ? $clog2(LOG_N) : 1;
  localparam int DW   = (PIPE > 1) ? $clog2(PIPE) : 1;

  localparam logic [BW-1:0]    LAST_B = BW'(HALF - 1);
  localparam logic [LW-1:0]    LAST_L = LW'(LOG_N - 1);
  localparam logic [DW-1:0]    LAST_D = DW'(PIPE - 1);
  localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    layer_q, layer_d;
  logic [BW-1:0]    bfly_q, bfly_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_addr0_q, rd_addr0_d;
  logic [LOG_N-1:0] rd_addr1_q, rd_addr1_d;
  logic [LOG_N-1:0] tw_addr_q, tw_addr_d;

  // Address arithmetic for the (layer, butterfly) pair being loaded
  logic [LOG_N-1:0] b_ext, grp, len, addr0, addr1, tw;
  int               sh_g;

  // Sequencer plus registered outputs. Outputs are derived from the *next*
  // state so they line up with it: cycle 0 after start already shows b = 0.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          layer_d = '0;
          bfly_d  = '0;
        end
      end
      S_ISSUE: begin
        if (bfly_q == LAST_B) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          bfly_d = bfly_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_D) begin
          if (layer_q == LAST_L) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + LW'(1);
            bfly_d  = '0;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    rd_en_d = (state_d == S_ISSUE);

    // len = N >> (l+1) = 1 << sh_g; group g = b >> sh_g; group base = g * 2len
    sh_g  = LOG_N - 1 - int'(layer_d);
    b_ext = {1'b0, bfly_d};
    grp   = b_ext >> sh_g;
    len   = ONE << sh_g;
    addr0 = (grp << (sh_g + 1)) | (b_ext & (len - ONE));
    addr1 = addr0 + len;
    tw    = (ONE << layer_d) + grp;

    // Addresses rest at zero whenever nothing is being issued
    rd_addr0_d = rd_en_d ? addr0 : '0;
    rd_addr1_d = rd_en_d ? addr1 : '0;
    tw_addr_d  = rd_en_d ? tw    : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      layer_q    <= '0;
      bfly_q     <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      bfly_q     <= bfly_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      tw_addr_q  <= tw_addr_d;
    end
  end

  // Write-back delay line: stage PIPE-1 holds what was read PIPE cycles ago.
  // Reset flushes it, so a transform aborted by reset writes nothing more.
  logic             wr_en_pipe_q [PIPE];
  logic             wr_en_pipe_d [PIPE];
  logic [LOG_N-1:0] wr_a0_pipe_q [PIPE];
  logic [LOG_N-1:0] wr_a0_pipe_d [PIPE];
  logic [LOG_N-1:0] wr_a1_pipe_q [PIPE];
  logic [LOG_N-1:0] wr_a1_pipe_d [PIPE];

  genvar gi;
  generate
    for (gi = 0; gi < PIPE; gi++) begin : g_wr_pipe
      if (gi == 0) begin : g_head
        assign wr_en_pipe_d[gi] = rd_en_q;
        assign wr_a0_pipe_d[gi] = rd_addr0_q;
        assign wr_a1_pipe_d[gi] = rd_addr1_q;
      end else begin : g_tail
        assign wr_en_pipe_d[gi] = wr_en_pipe_q[gi-1];
        assign wr_a0_pipe_d[gi] = wr_a0_pipe_q[gi-1];
        assign wr_a1_pipe_d[gi] = wr_a1_pipe_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          wr_en_pipe_q[gi] <= 1'b0;
          wr_a0_pipe_q[gi] <= '0;
          wr_a1_pipe_q[gi] <= '0;
        end else begin
          wr_en_pipe_q[gi] <= wr_en_pipe_d[gi];
          wr_a0_pipe_q[gi] <= wr_a0_pipe_d[gi];
          wr_a1_pipe_q[gi] <= wr_a1_pipe_d[gi];
        end
      end
    end
  endgenerate

`ifdef NTT_CTRL_PERF_EN
  // Cleared when a start is accepted, counts busy cycles, then holds
  logic [15:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (state_q == S_IDLE && start) begin
      cycle_cnt_d = '0;
    end else if (busy_q) begin
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_addr0_q;
  assign rd_addr1 = rd_addr1_q;
  assign tw_addr  = tw_addr_q;
  assign wr_en    = wr_en_pipe_q[PIPE-1];
  assign wr_addr0 = wr_a0_pipe_q[PIPE-1];
  assign wr_addr1 = wr_a1_pipe_q[PIPE-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
`timescale 1ns/1ps
// tb_ntt_ctrl -- bench for ntt_ctrl with default parameters.
// Expected read/write transactions are queued when a start is driven and
// popped as the controller issues them. A behavioural RAM, zeta ROM and
// butterfly close the loop so the final RAM can be compared with a
// software forward NTT.
module tb_ntt_ctrl;

  localparam int    LOG_N = 8;
  localparam int    N     = 256;
  localparam longint Q    = 64'd8380417;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy, done, rd_en, wr_en;
  logic [LOG_N-1:0] rd_addr0, rd_addr1, tw_addr, wr_addr0, wr_addr1;
`ifdef NTT_CTRL_PERF_EN
  logic [15:0]      cycle_cnt;
`endif

  ntt_ctrl #(.LOG_N(LOG_N), .RD_LAT(1), .BT_LAT(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
`ifdef NTT_CTRL_PERF_EN
    .wr_addr1 (wr_addr1),
    .cycle_cnt(cycle_cnt)
`else
    .wr_addr1 (wr_addr1)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [23:0] rd_q [$];   // {tw, addr0, addr1}
  logic [15:0] wr_q [$];   // {addr0, addr1}
  logic [23:0] mon_rd;
  logic [15:0] mon_wr;

  // Reference order of the textbook loop nest
  task automatic push_expected();
    int k = 0;
    for (int len = N / 2; len > 0; len = len / 2) begin
      for (int st = 0; st < N; st += 2 * len) begin
        k++;
        for (int j = st; j < st + len; j++) begin
          rd_q.push_back({8'(k), 8'(j), 8'(j + len)});
          wr_q.push_back({8'(j), 8'(j + len)});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      if (rd_q.size() == 0) begin
        check_val("rd_unexpected", 32'(rd_en), 32'd0);
      end else begin
        mon_rd = rd_q.pop_front();
        check_val("rd_tw", 32'(tw_addr), 32'(mon_rd[23:16]));
        check_val("rd_a0", 32'(rd_addr0), 32'(mon_rd[15:8]));
        check_val("rd_a1", 32'(rd_addr1), 32'(mon_rd[7:0]));
      end
    end
    if (wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        check_val("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        mon_wr = wr_q.pop_front();
        check_val("wr_a0", 32'(wr_addr0), 32'(mon_wr[15:8]));
        check_val("wr_a1", 32'(wr_addr1), 32'(mon_wr[7:0]));
      end
    end
  end

  // ---------------- behavioural datapath ----------------
  logic [22:0] ram      [N];
  logic [22:0] zeta_rom [N];
  logic [22:0] rd0_r, rd1_r, z_r, bo0_r, bo1_r;
  logic        ram_load = 1'b0;

  function automatic logic [22:0] mulmod(input logic [22:0] a, input logic [22:0] b);
    return 23'((longint'(a) * longint'(b)) % Q);
  endfunction

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < N; i++) ram[i] <= 23'(longint'(i) % Q);
    end else if (wr_en === 1'b1) begin
      ram[wr_addr0] <= bo0_r;
      ram[wr_addr1] <= bo1_r;
    end
    if (rd_en === 1'b1) begin
      rd0_r <= ram[rd_addr0];
      rd1_r <= ram[rd_addr1];
      z_r   <= zeta_rom[tw_addr];
    end
    bo0_r <= 23'((longint'(rd0_r) + longint'(mulmod(z_r, rd1_r))) % Q);
    bo1_r <= 23'((longint'(rd0_r) + Q - longint'(mulmod(z_r, rd1_r))) % Q);
  end

  // ---------------- software reference ----------------
  longint ref_a [N];

  function automatic int brv8(input int k);
    int r = 0;
    for (int b = 0; b < 8; b++) if (((k >> b) & 1) != 0) r |= (1 << (7 - b));
    return r;
  endfunction

  task automatic build_zetas();
    longint p;
    for (int k = 0; k < N; k++) begin
      p = 1;
      for (int e = 0; e < brv8(k); e++) p = (p * 1753) % Q;
      zeta_rom[k] = 23'(p);
    end
  endtask

  task automatic ref_init();
    for (int i = 0; i < N; i++) ref_a[i] = longint'(i) % Q;
  endtask

  task automatic ref_ntt();
    int k = 0;
    longint z, t;
    for (int len = N / 2; len > 0; len = len / 2) begin
      for (int st = 0; st < N; st += 2 * len) begin
        k++;
        z = longint'(zeta_rom[k]);
        for (int j = st; j < st + len; j++) begin
          t = (z * ref_a[j + len]) % Q;
          ref_a[j + len] = (ref_a[j] + Q - t) % Q;
          ref_a[j]       = (ref_a[j] + t) % Q;
        end
      end
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < N; i++)
      check_val($sformatf("%s[%0d]", tag, i), 32'(ram[i]), 32'(ref_a[i]));
  endtask

  // ---------------- cycle tracking ----------------
  int cur = 0;

  // Advance to the negedge of cycle n (relative to the last accepted start)
  task automatic goto_cyc(input int n);
    repeat (n - cur) @(posedge clk);
    cur = n;
    @(negedge clk);
  endtask

  // Called at a negedge; the following posedge samples start -> cycle 0
  task automatic launch(input bit load);
    start    = 1'b1;
    ram_load = load;
    push_expected();
    @(posedge clk);
    #1;
    start    = 1'b0;
    ram_load = 1'b0;
    cur      = 0;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"},  32'(busy),     32'd0);
    check_val({tag, "_done"},  32'(done),     32'd0);
    check_val({tag, "_rd_en"}, 32'(rd_en),    32'd0);
    check_val({tag, "_wr_en"}, 32'(wr_en),    32'd0);
    check_val({tag, "_ra0"},   32'(rd_addr0), 32'd0);
    check_val({tag, "_ra1"},   32'(rd_addr1), 32'd0);
    check_val({tag, "_tw"},    32'(tw_addr),  32'd0);
    check_val({tag, "_wa0"},   32'(wr_addr0), 32'd0);
    check_val({tag, "_wa1"},   32'(wr_addr1), 32'd0);
  endtask

  task automatic check_rd(input string tag, input int a0, input int a1, input int tw);
    check_val({tag, "_rd_en"}, 32'(rd_en),    32'd1);
    check_val({tag, "_a0"},    32'(rd_addr0), 32'(a0));
    check_val({tag, "_a1"},    32'(rd_addr1), 32'(a1));
    check_val({tag, "_tw"},    32'(tw_addr),  32'(tw));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_zetas();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Reset for 3 cycles while idle
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("rst_idle");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
`ifdef NTT_CTRL_PERF_EN
    check_val("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif

    // ---- Transform A: full run with data ----
    ref_init();
    ref_ntt();
    launch(1'b1);
    goto_cyc(0);    check_rd("a_c0", 0, 128, 1);
                    check_val("a_c0_busy", 32'(busy), 32'd1);
    goto_cyc(1);    check_rd("a_c1", 1, 129, 1);
    goto_cyc(2);    check_val("a_c2_wr_en", 32'(wr_en), 32'd1);
                    check_val("a_c2_wa0", 32'(wr_addr0), 32'd0);
                    check_val("a_c2_wa1", 32'(wr_addr1), 32'd128);
    goto_cyc(127);  check_rd("a_c127", 127, 255, 1);
    goto_cyc(128);  check_val("a_c128_rd_en", 32'(rd_en), 32'd0);
    goto_cyc(129);  check_val("a_c129_rd_en", 32'(rd_en), 32'd0);
    goto_cyc(130);  check_rd("a_c130", 0, 64, 2);
    goto_cyc(194);  check_rd("a_c194", 128, 192, 3);
    goto_cyc(257);  check_rd("a_c257", 191, 255, 3);
    goto_cyc(300);  start = 1'b1;              // ignored while busy
    goto_cyc(301);  start = 1'b0;
    goto_cyc(910);  check_rd("a_c910", 0, 1, 128);
    goto_cyc(911);  check_rd("a_c911", 2, 3, 129);
    goto_cyc(1037); check_rd("a_c1037", 254, 255, 255);
    goto_cyc(1039); check_val("a_c1039_wr_en", 32'(wr_en), 32'd1);
                    check_val("a_c1039_wa0", 32'(wr_addr0), 32'd254);
                    check_val("a_c1039_wa1", 32'(wr_addr1), 32'd255);
                    check_val("a_c1039_busy", 32'(busy), 32'd1);
                    check_val("a_c1039_done", 32'(done), 32'd0);
    goto_cyc(1040); check_val("a_c1040_done", 32'(done), 32'd1);
                    check_val("a_c1040_busy", 32'(busy), 32'd0);
                    check_val("a_c1040_rd_en", 32'(rd_en), 32'd0);
`ifdef NTT_CTRL_PERF_EN
                    check_val("a_cycle_cnt", 32'(cycle_cnt), 32'd1040);
`endif
    check_ram("a_ram");
    check_val("a_rdq_left", 32'(rd_q.size()), 32'd0);
    check_val("a_wrq_left", 32'(wr_q.size()), 32'd0);

    // ---- Transform B: started in the done cycle, aborted by reset ----
    ref_ntt();
    launch(1'b0);
    goto_cyc(0);    check_rd("b_c0", 0, 128, 1);
                    check_val("b_c0_done", 32'(done), 32'd0);
    goto_cyc(500);  reset = 1'b1;
    goto_cyc(501);  check_idle("b_c501");
`ifdef NTT_CTRL_PERF_EN
                    check_val("b_cycle_cnt", 32'(cycle_cnt), 32'd0);
`endif
                    rd_q.delete();
                    wr_q.delete();
                    reset = 1'b0;
    goto_cyc(502);  check_idle("b_c502");

    // ---- Transform C: restart from scratch ----
    goto_cyc(510);
    ref_init();
    ref_ntt();
    launch(1'b1);
    goto_cyc(0);    check_rd("c_c0", 0, 128, 1);
    goto_cyc(1);    check_rd("c_c1", 1, 129, 1);
    goto_cyc(50);   start = 1'b1;              // held 3 cycles while busy
    goto_cyc(53);   start = 1'b0;
                    check_rd("c_c53", 53, 181, 1);
    goto_cyc(1040); check_val("c_c1040_done", 32'(done), 32'd1);
                    check_val("c_c1040_busy", 32'(busy), 32'd0);
`ifdef NTT_CTRL_PERF_EN
                    check_val("c_cycle_cnt", 32'(cycle_cnt), 32'd1040);
`endif
    check_ram("c_ram");
    goto_cyc(1041); check_idle("c_c1041");
    check_val("c_rdq_left", 32'(rd_q.size()), 32'd0);
    check_val("c_wrq_left", 32'(wr_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
Name: ntt_ctrl

Overview:
Address and sequence controller for one 256-point forward NTT (ML-DSA, Cooley-Tukey, q = 8380417) on a single registered butterfly unit. It reads coefficient pairs from a dual-port coefficient RAM and twiddles from a zeta ROM, issuing one butterfly per cycle. The butterfly outputs are written back in place. Sits between the top-level polynomial engine (start/done handshake) and the butterfly/RAM datapath.

Parameters:
LOG_N, 8, log2 of polynomial length; N = 2^LOG_N coefficients, LOG_N layers, N/2 butterflies per layer
RD_LAT, 1, read latency of coefficient RAM and zeta ROM in cycles (>= 1)
BT_LAT, 1, butterfly latency in cycles (>= 1); PIPE = RD_LAT + BT_LAT

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
start  input  1  request a transform; sampled only in IDLE
busy  output  1  high while a transform is in progress
done  output  1  one-cycle pulse when the final write-back has been issued
rd_en  output  1  coefficient-RAM and zeta-ROM read strobe
rd_addr0  output  LOG_N  address of a[j]; drives the butterfly in0 path
rd_addr1  output  LOG_N  address of a[j+len]; drives the butterfly in1 path
tw_addr  output  LOG_N  zeta ROM index k (1..N-1); drives the phi path
wr_en  output  1  write-back strobe for both RAM ports
wr_addr0  output  LOG_N  destination of out0 (= a[j])
wr_addr1  output  LOG_N  destination of out1 (= a[j+len])

Behaviour:
- Reset: state IDLE. busy, done, rd_en and wr_en are 0. All address outputs are 0. The write-address delay line is cleared, so pending writes are discarded.
- States: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start = 1.
  - ISSUE -> DRAIN after the N/2-th butterfly of a layer.
  - DRAIN -> ISSUE for the next layer after PIPE cycles.
  - DRAIN -> IDLE after the last layer's drain.
- Cycle 0 is the first cycle after the edge that samples start. busy = 1 from cycle 0 through cycle LOG_N*(N/2+PIPE)-1.
- Layer l (0..LOG_N-1): len = N >> (l+1). Butterfly counter b runs 0..N/2-1, one per cycle, with rd_en = 1.
  - g = b >> (LOG_N-1-l)
  - rd_addr0 = (g << (LOG_N-l)) | (b & (len-1))
  - rd_addr1 = rd_addr0 + len
  - tw_addr = (1 << l) + g
- DRAIN: rd_en = 0 for exactly PIPE cycles. The last write of layer l lands before the first read of layer l+1, so there is no RAW hazard.
- Layer period = N/2 + PIPE cycles. Defaults give 130 cycles per layer.
- Write-back: wr_en, wr_addr0 and wr_addr1 are rd_en, rd_addr0 and rd_addr1 delayed by exactly PIPE cycles through a shift register. Out-of-range or partial writes never occur.
- done: asserted for one cycle at cycle LOG_N*(N/2+PIPE), which is 1040 with defaults. busy = 0 and state is IDLE in that same cycle.
- start handling:
  - start in the done cycle is accepted (back-to-back transforms).
  - start while busy is ignored.
- Reset mid-transform: the next cycle shows reset values. A later start restarts from layer 0, b = 0.
- Address arithmetic is unsigned, LOG_N bits, with no wrap. rd_addr1 max is N-1; tw_addr max is N-1. Index 0 of the zeta ROM is never addressed.

Optional Feature:
NTT_CTRL_PERF_EN
- Defined: adds output cycle_cnt [15:0].
  - Cleared to 0 on reset and on start acceptance.
  - Increments every busy cycle.
  - Holds its value from the done cycle until the next start; equals 1040 with defaults.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset asserted for 3 cycles mid-idle -> busy = done = rd_en = wr_en = 0, all addresses 0.
- start pulse, defaults ->
  - cycle 0: rd_addr0/1 = 0/128, tw_addr = 1
  - cycle 1: 1/129, tw_addr = 1
  - cycle 127: 127/255, tw_addr = 1
  - cycle 2: wr_en = 1 with wr_addr0/1 = 0/128
  - cycles 128-129: rd_en = 0
- Layer 1 ->
  - cycle 130: addresses 0/64, tw_addr = 2
  - cycle 194: 128/192, tw_addr = 3
  - cycle 257: last issue, 191/255, tw_addr = 3
- Layer 7 ->
  - cycle 910: addresses 0/1, tw_addr = 128
  - cycle 911: 2/3, tw_addr = 129
  - cycle 1037: 254/255, tw_addr = 255
  - cycle 1039: last wr_en, addresses 254/255
  - cycle 1040: done = 1, busy = 0
- reset at cycle 500, then start at 510, plus start pulses while busy -> reset values from cycle 501; the restart repeats the cycle-0 addresses; starts while busy cause no change.
- End-to-end with a behavioural RAM, zeta ROM and butterfly model, input a[i] = i mod q -> final RAM matches the software ML-DSA forward NTT for all 256 coefficients. With NTT_CTRL_PERF_EN defined, cycle_cnt = 1040.
